// File: rtl/calc_seq.sv
// Calculator operand-entry and execution sequencer: builds decimal operands A and B,
// then runs add, sub or an N-cycle shift-add multiply and presents the result.
module calc_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         digit_stb_i,
  input  logic [3:0]   digit_i,
  input  logic         op_stb_i,
  input  logic [1:0]   op_i,
  input  logic         eq_stb_i,
  output logic [N-1:0] disp_o,
  output logic         res_valid_o,
  output logic         ovf_o,
  output logic         busy_o
);

  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {S_A, S_B, S_EXEC, S_RES} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   res_q, res_d;
  logic [1:0]     op_q, op_d;
  logic           b_started_q, b_started_d;
  logic           ovf_q, ovf_d;
  logic           res_valid_q, res_valid_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mpl_q, mpl_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]   entry;
  logic [N+3:0]   entry_ext;
  logic [N+3:0]   entry_next;
  logic           digit_ok;
  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [2*N-1:0] acc_next;
  logic           do_clear;

  always_comb begin
    entry      = (state_q == S_B) ? b_q : a_q;
    entry_ext  = {4'b0000, entry};
    entry_next = (entry_ext << 3) + (entry_ext << 1) + (N+4)'(digit_i);
    digit_ok   = digit_stb_i && (digit_i <= 4'd9);
    sum        = {1'b0, a_q} + {1'b0, b_q};
    diff       = {1'b0, a_q} - {1'b0, b_q};
    acc_next   = acc_q + (mpl_q[0] ? mcand_q : '0);

    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    op_d        = op_q;
    b_started_d = b_started_q;
    ovf_d       = ovf_q;
    res_valid_d = 1'b0;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mpl_d       = mpl_q;
    cnt_d       = cnt_q;
    do_clear    = 1'b0;

    // eq outranks op, op outranks digit; only the winner acts
    case (state_q)
      S_A: begin
        if (eq_stb_i) begin
          res_d       = a_q;
          res_valid_d = 1'b1;
          state_d     = S_RES;
        end else if (op_stb_i) begin
          if (op_i == OP_CLR) begin
            do_clear = 1'b1;
          end else begin
            op_d        = op_i;
            b_d         = '0;
            b_started_d = 1'b0;
            state_d     = S_B;
          end
        end else if (digit_ok) begin
          a_d   = entry_next[N-1:0];
          ovf_d = ovf_q | (|entry_next[N+3:N]);
        end
      end
      S_B: begin
        if (eq_stb_i) begin
          acc_d   = '0;
          mcand_d = {{N{1'b0}}, a_q};
          mpl_d   = b_q;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (op_stb_i) begin
          if (op_i == OP_CLR) begin
            do_clear = 1'b1;
          end else begin
            op_d        = op_i;
            b_d         = '0;
            b_started_d = 1'b0;
          end
        end else if (digit_ok) begin
          b_d         = entry_next[N-1:0];
          b_started_d = 1'b1;
          ovf_d       = ovf_q | (|entry_next[N+3:N]);
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_SUB: begin
            res_d       = diff[N-1:0];
            ovf_d       = ovf_q | diff[N];
            res_valid_d = 1'b1;
            state_d     = S_RES;
          end
          OP_MUL: begin
            // one multiplier bit per cycle, LSB first
            acc_d   = acc_next;
            mcand_d = mcand_q << 1;
            mpl_d   = mpl_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
              res_d       = acc_next[N-1:0];
              ovf_d       = ovf_q | (|acc_next[2*N-1:N]);
              res_valid_d = 1'b1;
              state_d     = S_RES;
            end
          end
          default: begin
            res_d       = sum[N-1:0];
            ovf_d       = ovf_q | sum[N];
            res_valid_d = 1'b1;
            state_d     = S_RES;
          end
        endcase
      end
      S_RES: begin
        if (eq_stb_i) begin
          state_d = S_RES;
        end else if (op_stb_i) begin
          if (op_i == OP_CLR) begin
            do_clear = 1'b1;
          end else begin
            a_d         = res_q;
            op_d        = op_i;
            b_d         = '0;
            b_started_d = 1'b0;
            state_d     = S_B;
          end
        end else if (digit_ok) begin
          a_d     = N'(digit_i);
          ovf_d   = 1'b0;
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase

    if (do_clear) begin
      state_d     = S_A;
      a_d         = '0;
      b_d         = '0;
      res_d       = '0;
      op_d        = OP_ADD;
      b_started_d = 1'b0;
      ovf_d       = 1'b0;
      res_valid_d = 1'b0;
      acc_d       = '0;
      mcand_d     = '0;
      mpl_d       = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      op_q        <= OP_ADD;
      b_started_q <= 1'b0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mpl_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      op_q        <= op_d;
      b_started_q <= b_started_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mpl_q       <= mpl_d;
      cnt_q       <= cnt_d;
    end
  end

  // B is only shown once its first digit has arrived
  always_comb begin
    case (state_q)
      S_RES:   disp_o = res_q;
      S_A:     disp_o = a_q;
      default: disp_o = b_started_q ? b_q : a_q;
    endcase
  end

  assign busy_o      = (state_q == S_EXEC);
  assign res_valid_o = res_valid_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_calc_seq.sv
// Scoreboard bench for calc_seq: directed key sequences push expected results,
// a monitor pops them on every res_valid pulse.
module tb_calc_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         digitStb;
  logic [3:0]   digit;
  logic         opStb;
  logic [1:0]   op;
  logic         eqStb;
  logic [N-1:0] disp;
  logic         resValid;
  logic         ovf;
  logic         busy;

  typedef struct {
    logic [N-1:0] disp;
    logic         ovf;
  } exp_t;

  exp_t sbQueue[$];
  int   checkCount = 0;
  int   passCount  = 0;

  calc_seq #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_stb_i (digitStb),
    .digit_i     (digit),
    .op_stb_i    (opStb),
    .op_i        (op),
    .eq_stb_i    (eqStb),
    .disp_o      (disp),
    .res_valid_o (resValid),
    .ovf_o       (ovf),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // one-cycle strobe pattern; returns at the falling edge after it took effect
  task automatic applyStimulus(input logic dS, input logic [3:0] d, input logic oS,
                               input logic [1:0] o, input logic eS);
    @(negedge clk);
    digitStb = dS;
    digit    = d;
    opStb    = oS;
    op       = o;
    eqStb    = eS;
    @(negedge clk);
    digitStb = 1'b0;
    opStb    = 1'b0;
    eqStb    = 1'b0;
  endtask

  task automatic pressDigit(input int d);
    applyStimulus(1'b1, 4'(d), 1'b0, 2'b00, 1'b0);
  endtask

  task automatic pressOp(input logic [1:0] o);
    applyStimulus(1'b0, 4'd0, 1'b1, o, 1'b0);
  endtask

  task automatic pressEq();
    applyStimulus(1'b0, 4'd0, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic expectResult(input logic [N-1:0] d, input logic o);
    exp_t e;
    e.disp = d;
    e.ovf  = o;
    sbQueue.push_back(e);
  endtask

  task automatic waitExec(input string name, input int expBusy);
    int cycles = 0;
    while (busy && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput({name, " busy cycles"}, cycles, expBusy);
    checkOutput({name, " res_valid"}, resValid, 1);
    @(negedge clk);
    checkOutput({name, " res_valid pulse end"}, resValid, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resValid === 1'b1) begin
        if (sbQueue.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected res_valid: disp %0d with no result pending", disp);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("sb disp", disp, e.disp);
          checkOutput("sb ovf", ovf, e.ovf);
        end
      end
    end
  end

  initial begin : stimulus
    int w;
    rst = 1'b1; digitStb = 1'b0; digit = 4'd0; opStb = 1'b0; op = 2'b00; eqStb = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset disp", disp, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset ovf", ovf, 0);
    checkOutput("reset res_valid", resValid, 0);
    rst = 1'b0;

    // 12 + 34
    pressDigit(1); pressDigit(2);
    checkOutput("entry A=12", disp, 12);
    pressOp(2'b00);
    checkOutput("disp A before B digit", disp, 12);
    pressDigit(3); pressDigit(4);
    checkOutput("entry B=34", disp, 34);
    expectResult(8'd46, 1'b0);
    pressEq();
    waitExec("add 12+34", 1);

    // 5 - 7 wraps with borrow, next digit clears ovf
    pressDigit(5);
    checkOutput("digit after result", disp, 5);
    pressOp(2'b01); pressDigit(7);
    expectResult(8'd254, 1'b1);
    pressEq();
    waitExec("sub 5-7", 1);
    pressDigit(3);
    checkOutput("digit 3 disp", disp, 3);
    checkOutput("digit 3 clears ovf", ovf, 0);

    // 15 * 17 and 16 * 16
    pressOp(2'b11);
    checkOutput("clear disp", disp, 0);
    pressDigit(1); pressDigit(5); pressOp(2'b10); pressDigit(1); pressDigit(7);
    expectResult(8'd255, 1'b0);
    pressEq();
    waitExec("mul 15*17", 8);
    pressDigit(1); pressDigit(6); pressOp(2'b10); pressDigit(1); pressDigit(6);
    expectResult(8'd0, 1'b1);
    pressEq();
    waitExec("mul 16*16", 8);

    // entry overflow: 300 mod 256
    pressOp(2'b11);
    pressDigit(3); pressDigit(0); pressDigit(0);
    checkOutput("entry 300 disp", disp, 44);
    checkOutput("entry 300 ovf", ovf, 1);
    pressOp(2'b11);
    checkOutput("clear after ovf disp", disp, 0);
    checkOutput("clear after ovf ovf", ovf, 0);

    // eq outranks a simultaneous digit; non-decimal code ignored
    pressDigit(4); pressOp(2'b00); pressDigit(2);
    expectResult(8'd6, 1'b0);
    applyStimulus(1'b1, 4'd9, 1'b0, 2'b00, 1'b1);
    waitExec("eq beats digit", 1);
    pressDigit(12);
    checkOutput("digit 12 ignored disp", disp, 6);
    checkOutput("digit 12 ignored ovf", ovf, 0);

    // rst mid-multiply aborts without a result
    pressDigit(2); pressDigit(0); pressDigit(0);
    checkOutput("entry 200", disp, 200);
    pressOp(2'b10); pressDigit(3);
    pressEq();
    checkOutput("mul busy", busy, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort disp", disp, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort ovf", ovf, 0);
    checkOutput("abort res_valid", resValid, 0);
    repeat (10) @(negedge clk);

    // 20 + (empty B), then chained + 5
    pressDigit(2); pressDigit(0); pressOp(2'b00);
    expectResult(8'd20, 1'b0);
    pressEq();
    waitExec("add 20+0", 1);
    pressOp(2'b00); pressDigit(5);
    expectResult(8'd25, 1'b0);
    pressEq();
    waitExec("chain +5", 1);

    w = 0;
    while (sbQueue.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("scoreboard drained", sbQueue.size(), 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
